// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between the CPU data port
// (port 0) and a secondary bus master (port 1), one access at a time.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req*/we*/addr*/wdata*      per-port request, held until its gnt pulse
//   gnt0/gnt1                  this port's access is on the RAM bus now
//   rvalid0/rvalid1, rdata     registered read result, shared data bus
//   ram_sel/ram_we/ram_addr/ram_wdata/ram_rdata   RAM pins
//
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: ties alternate between
// ports. Undefined: port 0 always wins ties (port 1 may starve).
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_sel,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic              any_req;
    logic              win_nx;
    logic              win;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              take;

    assign any_req = req0 | req1;
    assign take    = (state == IDLE) & any_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Port granted most recently; reset to 1 so the first tie goes to port 0.
    logic last;

    always_comb begin
        win_nx = 1'b0;
        if (req0 & req1) win_nx = ~last;
        else             win_nx = req1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     last <= 1'b1;
        else if (take) last <= win_nx;
    end
`else
    always_comb begin
        win_nx = ~req0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: writes finish in ACCESS, reads take one extra RESP cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = lat_we ? IDLE : RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winner's fields so requesters may change them after gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take) begin
            win       <= win_nx;
            lat_we    <= win_nx ? we1 : we0;
            lat_addr  <= win_nx ? addr1 : addr0;
            lat_wdata <= win_nx ? wdata1 : wdata0;
        end
    end

    // Read response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= (state == RESP) & ~win;
            rvalid1 <= (state == RESP) & win;
            if (state == RESP) rdata <= ram_rdata;
        end
    end

    // RAM bus and grants decoded from registered state only
    assign ram_sel   = (state == ACCESS);
    assign ram_we    = ram_sel & lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign gnt0      = ram_sel & ~win;
    assign gnt1      = ram_sel & win;

endmodule
